// File: rtl/priority_encoder8_3_seq.sv
// Sequential 8-to-3 priority encoder: accepts a multi-hot vector, then emits each set index lowest-first.
// Optional macro ENC_ZERO_ERR_EN adds a registered err_zero pulse for accepted all-zero vectors.
module priority_encoder8_3_seq #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
`ifdef ENC_ZERO_ERR_EN
    output logic             err_zero,
`endif
    output logic             busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]       state_reg, state_next;
    logic [WIDTH-1:0] pending_reg, pending_next;
    logic [WIDTH-1:0] lowest_onehot;
    logic [IDX_W-1:0] lowest_idx;
    logic             single_bit;

    // Isolate the lowest set bit of pending; bit gi wins only if nothing below it is set.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lowest
            if (gi == 0) begin : g_first
                assign lowest_onehot[gi] = pending_reg[gi];
            end else begin : g_rest
                assign lowest_onehot[gi] = pending_reg[gi] & ~(|pending_reg[gi-1:0]);
            end
        end
    endgenerate

    always_comb begin
        lowest_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (lowest_onehot[i]) begin
                lowest_idx = lowest_idx | i[IDX_W-1:0];
            end
        end
    end

    assign single_bit = (pending_reg != '0) &&
                        ((pending_reg & (pending_reg - WIDTH'(1))) == '0);

    // Outputs depend on registers only, so no input-to-output path exists.
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DRAIN);
    assign busy      = (state_reg == DRAIN);
    assign out_idx   = lowest_idx;
    assign out_last  = single_bit;

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid && (in_vec != '0)) begin
                    pending_next = in_vec;
                    state_next   = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    pending_next = pending_reg & ~lowest_onehot;
                    if (single_bit) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                pending_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
        end
    end

`ifdef ENC_ZERO_ERR_EN
    logic err_zero_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_zero_reg <= 1'b0;
        end else begin
            err_zero_reg <= (state_reg == IDLE) && in_valid && (in_vec == '0);
        end
    end

    assign err_zero = err_zero_reg;
`endif

endmodule

// File: tb/tb_priority_encoder8_3_seq.sv
// Scoreboard bench for priority_encoder8_3_seq: expected indices are queued on accept, compared on each beat.
module tb_priority_encoder8_3_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_last;
    logic       busy;
`ifdef ENC_ZERO_ERR_EN
    logic       err_zero;
`endif

    int checks   = 0;
    int failures = 0;
    bit checking = 1'b0;
    bit exp_err  = 1'b0;
    int exp_q[$];

    always #5 clk = ~clk;

    priority_encoder8_3_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
`ifdef ENC_ZERO_ERR_EN
        .err_zero  (err_zero),
`endif
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: compare outputs at the falling edge, advance the model, then cross the rising edge.
    task automatic step();
        bit drain;
        @(negedge clk);
        drain = (exp_q.size() != 0);
        if (checking) begin
            check("out_valid", {31'd0, out_valid}, {31'd0, drain});
            check("in_ready", {31'd0, in_ready}, {31'd0, !drain});
            check("busy", {31'd0, busy}, {31'd0, drain});
            if (drain) begin
                check("out_idx", {29'd0, out_idx}, exp_q[0]);
                check("out_last", {31'd0, out_last}, {31'd0, exp_q.size() == 1});
                $display("beat idx=%0d last=%0b ready=%0b", out_idx, out_last, out_ready);
            end else begin
                check("idle_idx", {29'd0, out_idx}, 32'd0);
                check("idle_last", {31'd0, out_last}, 32'd0);
            end
`ifdef ENC_ZERO_ERR_EN
            check("err_zero", {31'd0, err_zero}, {31'd0, exp_err});
`endif
        end
        if (rst) begin
            exp_q.delete();
            exp_err = 1'b0;
        end else begin
            exp_err = 1'b0;
            if (!drain) begin
                if (in_valid) begin
                    if (in_vec == 8'd0) begin
                        exp_err = 1'b1;
                    end else begin
                        for (int i = 0; i < 8; i++) begin
                            if (in_vec[i]) exp_q.push_back(i);
                        end
                    end
                end
            end else if (out_ready) begin
                void'(exp_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v);
        in_valid = 1'b1;
        in_vec   = v;
        $display("send vec=%02h", v);
        step();
        in_valid = 1'b0;
        in_vec   = 8'd0;
    endtask

    // Drain the queued indices; ready_pat gives out_ready per cycle (bit 0 first, repeating).
    task automatic drain(input logic [7:0] ready_pat, input bit spam_ff);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            out_ready = ready_pat[n % 8];
            if (spam_ff) begin
                in_valid = 1'b1;
                in_vec   = 8'hFF;
            end
            step();
            n++;
        end
        check("drain_done", exp_q.size(), 32'd0);
        in_valid  = 1'b0;
        in_vec    = 8'd0;
        out_ready = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_vec    = 8'd0;
        out_ready = 1'b1;
        step();
        step();
        rst      = 1'b0;
        checking = 1'b1;
        step();

        send(8'b0000_0100);
        drain(8'hFF, 1'b0);
        step();

        send(8'b1010_0011);
        drain(8'hFF, 1'b0);

        // Stall pattern 1,0,0,1,1,1 then keep ready high.
        send(8'b1010_0011);
        drain(8'b1111_1001, 1'b0);

        send(8'b0100_1001);
        drain(8'hFF, 1'b1);

        // Back-to-back: next vector offered the cycle after the final beat.
        send(8'b0001_1000);
        drain(8'hFF, 1'b0);
        send(8'b1000_0000);
        drain(8'b0101_0101, 1'b0);

        send(8'b1000_0011);
        out_ready = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        send(8'h10);
        drain(8'hFF, 1'b0);

        send(8'h00);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
